dot_product_feeder: RTL
=======================

# dot_product_feeder

Transmit-side driver for the `dot_product` serial engine. It accepts a pair of 3-element unsigned vectors on a valid/ready interface and serializes them onto the engine's byte input, one byte per clock, in the order a1, a2, a3, b1, b2, b3. It captures the engine's `dout`/`run` result and returns it on a valid/ready result interface. The engine consumes a byte every cycle unconditionally, so the feeder keeps the 6-slot frame alignment by sending idle all-zero frames whenever no vector is pending.

## Interface
- `WIDTH`, 8: element width in bits.
- `RES_W`, 2*WIDTH+2 (18): result width. Sized for the worst case 3·(2^WIDTH−1)^2.
- `clk`  in  1: single clock, rising edge.
- `resetn`  in  1: asynchronous, active-low reset. Shared with the attached `dot_product` instance.
- `in_valid`  in  1: vector pair offered.
- `in_ready`  out  1: vector pair accepted on an edge where `in_valid && in_ready`.
- `in_a`  in  3×WIDTH: a1..a3, element 0 = a1.
- `in_b`  in  3×WIDTH: b1..b3, element 0 = b1.
- `tx_byte`  out  WIDTH: drives engine `din`.
- `rx_dout`  in  RES_W: engine `dout`.
- `rx_run`  in  1: engine `run`.
- `res_valid`  out  1: result available.
- `res_ready`  in  1: result consumed on an edge where `res_valid && res_ready`.
- `res_data`  out  RES_W: dot product, in acceptance order.

## Operation
- Slot counter `slot` runs 0..5 and wraps to 0. It advances every cycle and stays in lockstep with the engine's internal count, because both leave reset together.
- Frame register holds 6 bytes and a `cur_real` tag. `tx_byte = frame[slot]`, selected combinationally from registers.
- On an edge with `slot==5`:
  - If `in_valid && in_ready`, load {a1,a2,a3,b1,b2,b3} and set `cur_real=1`.
  - Otherwise, load all zeros and set `cur_real=0` (idle frame).
  - In both cases, `pend_real <= cur_real`.
- `in_ready = (slot==5) && (fifo_count + cur_real < 2)`. This is conservative: a same-cycle pop is not credited.
- On an edge with `slot==0`:
  - If `rx_run && pend_real`, push `rx_dout` into the result FIFO.
  - Then clear `pend_real`.
  - If `rx_run` is seen while `pend_real=0` (idle frame, or the engine's reset-time `run=1`), the result is discarded.
- Result FIFO: 2 entries, first-word fall-through. `res_valid = !empty`, `res_data = head`.
  - A simultaneous push and pop is allowed.
  - The credit rule guarantees a push never hits a full FIFO. The RTL includes an assertion for this.
- Arithmetic: the feeder computes nothing. Results pass through unmodified at RES_W bits.

## Timing
- Reset values: `slot=0`, frame=0, `cur_real=0`, `pend_real=0`, FIFO empty. Resulting outputs: `tx_byte=0`, `in_ready=0`, `res_valid=0`, `res_data=0`.
- First acceptance opportunity is in the 6th cycle after reset release (`slot==5`). Frame 0 after reset is always idle.
- Maximum throughput: 1 vector per 6 cycles.
- Latency, with acceptance at edge T:
  - Bytes are sampled by the engine at T+1..T+6.
  - `rx_run` is high during the cycle after T+6.
  - The FIFO push happens at T+7, so `res_valid` is high from T+7 (7 cycles).
- Downstream stall: with `res_ready=0` the FIFO fills and `in_ready` drops. Idle frames continue, so alignment is never lost.
- Reset mid-frame: all state clears immediately. In-flight and queued results are dropped. The engine is reset by the same `resetn`, so alignment restarts at slot 0.

## Structure
- Package `dot_product_pkg`:
  - constants `DP_SLOTS=6`, `DP_WIDTH=8`, `DP_RES_W=18`;
  - typedef `dp_vec_t` (3×WIDTH packed array);
  - typedef `dp_slot_t` (3-bit).
  The engine will migrate to this package.
- One sub-module, `dp_result_fifo`: a 2-deep FIFO with count output, parameterized by data width.

## Test plan
All scenarios run with a `dot_product` instance connected.

1. Reset release with `in_valid=0` for 30 cycles: `tx_byte` stays 0, `res_valid` never asserts, and the reset-time `run` is discarded.
2. Offer a={1,2,3}, b={4,5,6} and hold `in_valid`. Acceptance occurs at the first `slot==5`. `tx_byte` then sequences 1,2,3,4,5,6, and `res_valid` rises 7 cycles after acceptance with `res_data=32`.
3. Offer a={255,255,255}, b={255,255,255}: `res_data=195075` (0x2FA03), with no truncation.
4. Back-to-back vectors {1,1,1}·{1,1,1}, {2,0,0}·{3,0,0}, {0,0,7}·{0,0,9} with `res_ready=1`: accepted every 6 cycles; results 3, 6, 63 in order.
5. Hold `res_ready=0` and offer 4 vectors: exactly 2 are accepted and `in_ready` stays 0 after that. Releasing `res_ready` drains the results in order, and acceptance resumes at the next `slot==5`.
6. Assert `resetn=0` while the 3rd byte of a real frame is on `tx_byte`: outputs take their reset values immediately. A vector offered after release returns a correct result, which confirms alignment is restored.

Source files
------------

// File: rtl/dot_product_pkg.sv
// Shared constants and types for the dot_product engine and its byte-serial feeder.
// Frame layout: six byte slots per vector pair, a1..a3 then b1..b3.
package dot_product_pkg;

    localparam int DP_SLOTS = 6;
    localparam int DP_ELEMS = 3;
    localparam int DP_WIDTH = 8;
    localparam int DP_RES_W = 18;

    typedef logic [DP_ELEMS-1:0][DP_WIDTH-1:0] dp_vec_t;
    typedef logic [2:0]                        dp_slot_t;

    localparam dp_slot_t DP_SLOT_FIRST = 3'd0;
    localparam dp_slot_t DP_SLOT_LAST  = 3'd5;

    function automatic dp_slot_t dp_slot_next(input dp_slot_t s);
        dp_slot_t n;
        if (s == DP_SLOT_LAST) begin
            n = DP_SLOT_FIRST;
        end else begin
            n = s + 3'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/dot_product_feeder_result_fifo.sv
// Two-entry first-word-fall-through result FIFO with occupancy count,
// plus a checker that flags any push arriving while the FIFO is full.
module dp_result_fifo #(
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic [1:0]        count
);

    logic [1:0][DATA_W-1:0] mem_q, mem_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic [1:0]             count_q, count_d;
    logic                   do_push_s, do_pop_s;

    // Next-state logic: a push into a full FIFO is dropped unless a pop frees a slot.
    always_comb begin
        do_pop_s  = pop && (count_q != 2'd0);
        do_push_s = push && ((count_q != 2'd2) || do_pop_s);
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

module dp_result_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic full
);

    // The acceptance credit must leave room for every result the engine returns.
    a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);

endmodule

// File: rtl/dot_product_feeder.sv
// Serializes vector pairs onto the dot_product engine byte input in fixed
// six-slot frames and returns the engine results through a small FIFO.
module dot_product_feeder
    import dot_product_pkg::*;
#(
    parameter int WIDTH = DP_WIDTH,
    parameter int RES_W = 2 * WIDTH + 2
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DP_ELEMS-1:0][WIDTH-1:0]   in_a,
    input  logic [DP_ELEMS-1:0][WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]                 tx_byte,
    input  logic [RES_W-1:0]                 rx_dout,
    input  logic                             rx_run,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [RES_W-1:0]                 res_data
);

    dp_slot_t                          slot_q, slot_d;
    logic [DP_SLOTS-1:0][WIDTH-1:0]    frame_q, frame_d;
    logic                              cur_real_q, cur_real_d;
    logic                              pend_real_q, pend_real_d;

    logic                              credit_ok_s;
    logic                              in_ready_s;
    logic                              accept_s;
    logic                              push_s;
    logic                              pop_s;
    logic [WIDTH-1:0]                  tx_byte_s;
    logic [RES_W-1:0]                  fifo_head_s;
    logic                              fifo_empty_s;
    logic                              fifo_full_s;
    logic [1:0]                        fifo_count_s;

    // A frame still in flight will push later, so it consumes a credit until then.
    assign credit_ok_s = ({1'b0, fifo_count_s} + {2'b00, cur_real_q}) < 3'd2;
    assign in_ready_s  = (slot_q == DP_SLOT_LAST) && credit_ok_s;
    assign accept_s    = in_valid && in_ready_s;
    assign push_s      = (slot_q == DP_SLOT_FIRST) && rx_run && pend_real_q;
    assign pop_s       = res_ready && !fifo_empty_s;

    // Next-state logic: slot advance, frame load at the last slot, real-frame tag pipeline.
    always_comb begin
        slot_d      = dp_slot_next(slot_q);
        frame_d     = frame_q;
        cur_real_d  = cur_real_q;
        pend_real_d = pend_real_q;
        if (slot_q == DP_SLOT_LAST) begin
            pend_real_d = cur_real_q;
            if (accept_s) begin
                for (int i = 0; i < DP_ELEMS; i++) begin
                    frame_d[i]            = in_a[i];
                    frame_d[i + DP_ELEMS] = in_b[i];
                end
                cur_real_d = 1'b1;
            end else begin
                frame_d    = '0;
                cur_real_d = 1'b0;
            end
        end else if (slot_q == DP_SLOT_FIRST) begin
            pend_real_d = 1'b0;
        end else begin
            pend_real_d = pend_real_q;
        end
    end

    // Slot counter, frame bytes and real-frame tags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_q      <= DP_SLOT_FIRST;
            frame_q     <= '0;
            cur_real_q  <= 1'b0;
            pend_real_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            frame_q     <= frame_d;
            cur_real_q  <= cur_real_d;
            pend_real_q <= pend_real_d;
        end
    end

    // Byte currently presented to the engine.
    always_comb begin
        case (slot_q)
            3'd0:    tx_byte_s = frame_q[0];
            3'd1:    tx_byte_s = frame_q[1];
            3'd2:    tx_byte_s = frame_q[2];
            3'd3:    tx_byte_s = frame_q[3];
            3'd4:    tx_byte_s = frame_q[4];
            3'd5:    tx_byte_s = frame_q[5];
            default: tx_byte_s = '0;
        endcase
    end

    dp_result_fifo #(
        .DATA_W (RES_W)
    ) u_result_fifo (
        .clk       (clk),
        .rst_n     (resetn),
        .push      (push_s),
        .push_data (rx_dout),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s)
    );

    dp_result_fifo_chk u_result_fifo_chk (
        .clk   (clk),
        .rst_n (resetn),
        .push  (push_s),
        .full  (fifo_full_s)
    );

    assign in_ready  = in_ready_s;
    assign tx_byte   = tx_byte_s;
    assign res_valid = !fifo_empty_s;
    assign res_data  = fifo_head_s;

endmodule
